seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side decoder for the multiplexed 7-segment scan bus (segment byte plus one-hot digit select) that the clock top drives to the board display. It samples the scan bus, waits for each digit slot to settle, decodes the glyph back into a 4-bit code, and assembles all 8 slots into a frame. Each completed frame is published atomically with a one-cycle strobe. It sits beside the clock top, on a loopback of its display outputs, for on-board readback and self-check.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a digit slot is captured (≥2).
- TIMEOUT_CYCLES, 1000000: cycles without a completed frame before `stale` asserts.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- seg_in  input  8  segment byte; bit0=a … bit6=g, bit7=dp; 1 = lit.
- chs_in  input  8  digit select; bit i selects slot i; 1 = active.
- digit_code  output  32  slot i code in [4i+3:4i].
- dp_out  output  8  slot i decimal point.
- frame_valid  output  1  one-cycle pulse when `digit_code`/`dp_out` update.
- frame_err  output  1  error status of the last published frame.
- stale  output  1  no frame completed within TIMEOUT_CYCLES.

## Operation
- Input stage: `{seg_in, chs_in}` is registered every cycle into `smp`.
- Stability counter:
  - `stab` resets to 0 whenever `smp` differs from its previous value; otherwise increments.
  - `stab` saturates at STABLE_CYCLES-1.
  - A `taken` flag allows only one capture per stable period; `taken` clears on any change.
- Capture occurs when `stab` reaches STABLE_CYCLES-1 and `taken`=0, classified by chs:
  - chs==0: blanking interval; nothing captured, no error.
  - chs one-hot (slot i): glyph decoded into shadow slot i, dp into shadow dp i, mask bit i set.
  - chs multi-hot: no slot written; frame-error accumulator set.
- Glyph decode on seg[6:0]:
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - 0x00→4'hA (blank).
  - Any other pattern→4'hF and sets the frame-error accumulator.
- Re-capture of a slot already in the mask overwrites the shadow value. This is not an error.
- Frame completion (mask == 8'hFF):
  - Copy shadow to `digit_code`/`dp_out`.
  - `frame_err` ← accumulator, including the completing capture.
  - Pulse `frame_valid`.
  - Clear mask and accumulator.
- Timeout:
  - Counter clears on every `frame_valid`.
  - When it reaches TIMEOUT_CYCLES, `stale`=1 and the counter holds.
  - The next `frame_valid` clears `stale`.
  - Published outputs are kept while stale.
- Reset:
  - All outputs 0: `digit_code`=0, `dp_out`=0, `frame_valid`=0, `frame_err`=0, `stale`=0.
  - mask, shadow, accumulator, `stab`, `taken`, and the timeout counter cleared; `smp`=0.
  - Reset mid-frame discards the partial frame.

## Timing
- Inputs held constant from before edge t: registered at edge t; capture at edge t+STABLE_CYCLES-1.
- Completing capture at edge c: `frame_valid`, `digit_code`, `dp_out`, `frame_err` update at edge c+1. `frame_valid` is high for exactly one cycle.
- Slot dwell shorter than STABLE_CYCLES samples: ignored. The slot stays missing from the mask.
- Simultaneous completion and timeout expiry: completion wins. Counter clears and `stale` stays 0.

## Configuration
- `SEG_SCAN_ACTIVE_LOW_EN`:
  - Defined: `seg_in` and `chs_in` are inverted at the input stage (0 = lit/active); everything downstream is unchanged.
  - Undefined: active-high as specified above.

## Test plan
- Scan slots 0..7 with glyphs for 1,2,3,4,5,6,7,8, 6 cycles each, STABLE_CYCLES=4 → one `frame_valid`; `digit_code`=32'h87654321, `frame_err`=0.
- Repeat with slot 3 held for only 2 cycles → no `frame_valid`. Re-scan slot 3 for 6 cycles → `frame_valid` one cycle later, with all eight slots correct.
- Slot 5 seg=0x49 (invalid) → frame published with nibble 5 = F and `frame_err`=1. Next clean frame → `frame_err`=0.
- chs=8'h03 stable for 6 cycles mid-frame → no slot written; the frame completes with `frame_err`=1.
- Slot 0 seg=0x80 → nibble 0 = A, `dp_out[0]`=1. Then TIMEOUT_CYCLES=100 with chs held at 0 → `stale`=1 at cycle 100; the next frame clears it.
- Assert rst after 4 slots captured, then scan 4 more slots → no `frame_valid`; all outputs remain 0.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Scan-bus readback: samples {seg, chs}, captures each settled digit slot, and publishes full frames.
// Optional SEG_SCAN_ACTIVE_LOW_EN inverts seg_in/chs_in at the input stage.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [7:0]  chs_in,
  output logic [31:0] digit_code,
  output logic [7:0]  dp_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        stale
);

  localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

  logic [15:0]   smp_in, smp_q;
  logic [SW-1:0] stab_q, stab_d;
  logic          taken_q, taken_d;
  logic          changed, capture;
  logic [7:0]    seg_q, chs_q;
  logic [3:0]    glyph_code;
  logic          glyph_bad;
  logic          is_multi, is_onehot;
  logic [7:0]    slot_wr, mask_q, mask_d;
  logic          acc_q, acc_d, complete;
  logic          pend_q, pend_err_q;
  logic [3:0]    shadow_code_q [8];
  logic [7:0]    shadow_dp_q;
  logic [31:0]   shadow_flat;
  logic [31:0]   digit_code_q;
  logic [7:0]    dp_out_q;
  logic          frame_valid_q, frame_err_q, stale_q;
  logic [TW-1:0] to_cnt_q;

`ifdef SEG_SCAN_ACTIVE_LOW_EN
  assign smp_in = ~{seg_in, chs_in};
`else
  assign smp_in = {seg_in, chs_in};
`endif

  assign seg_q = smp_q[15:8];
  assign chs_q = smp_q[7:0];

  // Capture fires on the edge where the counter reaches its saturation value.
  always_comb begin
    changed = (smp_in != smp_q);
    stab_d  = '0;
    if (!changed) stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
    capture = !changed && !taken_q && (stab_d == STAB_MAX);
    taken_d = changed ? 1'b0 : (taken_q | capture);
  end

  always_comb begin
    glyph_bad  = 1'b0;
    glyph_code = 4'hF;
    case (seg_q[6:0])
      7'h3F: glyph_code = 4'h0;
      7'h06: glyph_code = 4'h1;
      7'h5B: glyph_code = 4'h2;
      7'h4F: glyph_code = 4'h3;
      7'h66: glyph_code = 4'h4;
      7'h6D: glyph_code = 4'h5;
      7'h7D: glyph_code = 4'h6;
      7'h07: glyph_code = 4'h7;
      7'h7F: glyph_code = 4'h8;
      7'h6F: glyph_code = 4'h9;
      7'h00: glyph_code = 4'hA;
      default: glyph_bad = 1'b1;
    endcase
  end

  always_comb begin
    is_multi  = |(chs_q & (chs_q - 8'd1));
    is_onehot = (chs_q != 8'd0) && !is_multi;
    slot_wr   = (capture && is_onehot) ? chs_q : 8'd0;
    mask_d    = mask_q | slot_wr;
    acc_d     = acc_q | (capture && (is_multi || (is_onehot && glyph_bad)));
    complete  = capture && is_onehot && (mask_d == 8'hFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_q      <= '0;
      stab_q     <= '0;
      taken_q    <= 1'b0;
      mask_q     <= '0;
      acc_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      smp_q   <= smp_in;
      stab_q  <= stab_d;
      taken_q <= taken_d;
      pend_q  <= complete;
      if (complete) begin
        mask_q     <= '0;
        acc_q      <= 1'b0;
        pend_err_q <= acc_d;
      end else begin
        mask_q <= mask_d;
        acc_q  <= acc_d;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_code_q[gi] <= '0;
          shadow_dp_q[gi]   <= 1'b0;
        end else if (slot_wr[gi]) begin
          shadow_code_q[gi] <= glyph_code;
          shadow_dp_q[gi]   <= seg_q[7];
        end
      end
      assign shadow_flat[4*gi+3:4*gi] = shadow_code_q[gi];
    end
  endgenerate

  // Publishing one edge after the completing capture lets the shadow settle first.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_code_q  <= '0;
      dp_out_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      stale_q       <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      frame_valid_q <= pend_q;
      if (pend_q) begin
        digit_code_q <= shadow_flat;
        dp_out_q     <= shadow_dp_q;
        frame_err_q  <= pend_err_q;
        to_cnt_q     <= '0;
        stale_q      <= 1'b0;
      end else if (to_cnt_q != TO_MAX) begin
        to_cnt_q <= to_cnt_q + 1'b1;
        if (to_cnt_q == TO_MAX - 1'b1) stale_q <= 1'b1;
      end
    end
  end

  assign digit_code  = digit_code_q;
  assign dp_out      = dp_out_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: expected frames are queued by the stimulus and
// checked by an independent monitor whenever frame_valid is seen.
module tb_seg_scan_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  seg_in;
  logic [7:0]  chs_in;
  logic [31:0] digit_code;
  logic [7:0]  dp_out;
  logic        frame_valid;
  logic        frame_err;
  logic        stale;

  seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .chs_in(chs_in),
    .digit_code(digit_code), .dp_out(dp_out), .frame_valid(frame_valid),
    .frame_err(frame_err), .stale(stale)
  );

  typedef struct {
    logic [31:0] code;
    logic [7:0]  dp;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;
  int   exp_valid = 0;
  logic fv_prev = 1'b0;
  logic [7:0] gl [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (frame_valid) begin
      n_valid++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_frame: got code=%h dp=%h err=%b, required no frame", digit_code, dp_out, frame_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (digit_code !== e.code || dp_out !== e.dp || frame_err !== e.err) begin
          n_fail++;
          $display("FAIL frame: got code=%h dp=%h err=%b, required code=%h dp=%h err=%b",
                   digit_code, dp_out, frame_err, e.code, e.dp, e.err);
        end else begin
          $display("frame code=%h dp=%h err=%b ok", digit_code, dp_out, frame_err);
        end
      end
      if (fv_prev) begin
        n_checks++;
        n_fail++;
        $display("FAIL valid_width: got frame_valid high 2 cycles, required 1");
      end
    end
    fv_prev = frame_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] code, input logic [7:0] dp, input logic err);
    exp_t e;
    e.code = code;
    e.dp   = dp;
    e.err  = err;
    exp_q.push_back(e);
    exp_valid++;
  endtask

  task automatic scan(input logic [7:0] s, input logic [7:0] c, input int n);
    seg_in = s;
    chs_in = c;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) scan(gl[i+1], 8'(1 << i), 6);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_code"}, digit_code, 32'h0);
    chk({name, "_dp"}, {24'h0, dp_out}, 32'h0);
    chk({name, "_err_stale"}, {30'h0, frame_err, stale}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    seg_in = 8'h00;
    chs_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset_valid", {31'h0, frame_valid}, 32'h0);
    rst = 1'b0;

    // Clean frame 1..8.
    push_exp(32'h87654321, 8'h00, 1'b0);
    scan_range(0, 7);
    chk("t1_count", n_valid, exp_valid);

    // Short dwell on slot 3, then a proper re-scan completes the frame.
    scan_range(0, 2);
    scan(gl[4], 8'h08, 2);
    scan_range(4, 7);
    chk("t2_no_frame", n_valid, exp_valid);
    push_exp(32'h87654321, 8'h00, 1'b0);
    seg_in = gl[4];
    chs_in = 8'h08;
    repeat (4) @(posedge clk);
    #1;
    chk("t2_fv_at_capture", {31'h0, frame_valid}, 32'h0);
    @(posedge clk);
    #1;
    chk("t2_fv_after_capture", {31'h0, frame_valid}, 32'h1);
    @(posedge clk);
    #1;
    chk("t2_fv_drop", {31'h0, frame_valid}, 32'h0);
    chk("t2_count", n_valid, exp_valid);

    // Invalid glyph on slot 5, then a clean frame clears the error.
    push_exp(32'h87F54321, 8'h00, 1'b1);
    scan_range(0, 4);
    scan(8'h49, 8'h20, 6);
    scan_range(6, 7);
    push_exp(32'h87654321, 8'h00, 1'b0);
    scan_range(0, 7);
    chk("t3_count", n_valid, exp_valid);

    // Multi-hot select mid-frame flags the frame.
    push_exp(32'h87654321, 8'h00, 1'b1);
    scan_range(0, 3);
    scan(8'h06, 8'h03, 6);
    scan_range(4, 7);
    chk("t4_count", n_valid, exp_valid);

    // Blank glyph with dp on slot 0, then timeout with the bus blanked.
    push_exp(32'h8765432A, 8'h01, 1'b0);
    scan(8'h80, 8'h01, 6);
    scan_range(1, 6);
    seg_in = gl[8];
    chs_in = 8'h80;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_fv", {31'h0, frame_valid}, 32'h1);
    seg_in = 8'h00;
    chs_in = 8'h00;
    repeat (99) @(posedge clk);
    #1;
    chk("t5_stale_before", {31'h0, stale}, 32'h0);
    @(posedge clk);
    #1;
    chk("t5_stale_at_100", {31'h0, stale}, 32'h1);
    chk("t5_code_kept", digit_code, 32'h8765432A);
    chk("t5_dp_kept", {24'h0, dp_out}, 32'h1);
    push_exp(32'h87654321, 8'h00, 1'b0);
    scan_range(0, 7);
    chk("t5_stale_cleared", {31'h0, stale}, 32'h0);
    chk("t5_count", n_valid, exp_valid);

    // Reset mid-frame discards the partial frame.
    scan_range(0, 3);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle("t6_after_reset");
    scan_range(4, 7);
    chk_idle("t6_after_scan");
    chk("t6_count", n_valid, exp_valid);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
